tx_chan_sched: RTL



---
 rtl/tx_chan_sched.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_chan_sched.sv
// Round-robin scheduler sharing one TX list processor between NCHAN DMA channels.
// Grants one requester, starts the list processor and routes its outcome back.
module tx_chan_sched #(
    parameter int unsigned NCHAN   = 5,
    parameter int unsigned CHW     = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  macPITxClk,
    input  logic                  macPITxClkHardRst_n,
    input  logic                  macPITxClkSoftRst_n,
    input  logic [NCHAN-1:0]      chanReq,
    input  logic [32*NCHAN-1:0]   chanStatusPtr,
    input  logic                  lpDone_p,
    input  logic                  lpHalt_p,
    input  logic                  lpDead_p,
    input  logic                  lpProgress_p,
    input  logic                  lpAbortAck_p,
    output logic                  lpStart_p,
    output logic [31:0]           lpStatusPtr,
    output logic [CHW-1:0]        lpChanId,
    output logic                  lpAbort_p,
    output logic [NCHAN-1:0]      chanGrant,
    output logic [NCHAN-1:0]      chanHalt_p,
    output logic [NCHAN-1:0]      chanDead_p,
    output logic                  timeoutErr,
    output logic [5:0]            schedState
);

    localparam int unsigned SW = CHW + 1;
    localparam int unsigned WDW = 16;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        ARB     = 6'b000010,
        START   = 6'b000100,
        BUSY    = 6'b001000,
        ABORT   = 6'b010000,
        RELEASE = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        OC_NONE = 2'd0,
        OC_HALT = 2'd1,
        OC_DEAD = 2'd2
    } outcome_t;

    state_t               state, stateNxt;
    outcome_t             outcome, outcomeNxt;
    logic [CHW-1:0]       rrPtr, rrPtrNxt;
    logic [WDW-1:0]       wdCnt, wdCntNxt;

    logic                 lpStartNxt;
    logic [31:0]          lpStatusPtrNxt;
    logic [CHW-1:0]       lpChanIdNxt;
    logic                 lpAbortNxt;
    logic [NCHAN-1:0]     chanGrantNxt;
    logic [NCHAN-1:0]     chanHaltNxt;
    logic [NCHAN-1:0]     chanDeadNxt;
    logic                 timeoutErrNxt;

    logic                 winFound;
    logic [CHW-1:0]       winIdx;
    logic [SW-1:0]        sumIdx;
    logic [CHW-1:0]       candIdx;
    logic                 wdExpire;

    // First requester at or above rrPtr, wrapping modulo NCHAN.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        sumIdx   = '0;
        candIdx  = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            sumIdx  = SW'(rrPtr) + SW'(k);
            candIdx = (sumIdx >= SW'(NCHAN)) ? CHW'(sumIdx - SW'(NCHAN)) : CHW'(sumIdx);
            if (!winFound && chanReq[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    assign wdExpire = (TIMEOUT != 0) && (wdCnt == WD_LAST) && !lpProgress_p;

    // Next-state and registered-output values.
    always_comb begin
        stateNxt       = state;
        outcomeNxt     = outcome;
        rrPtrNxt       = rrPtr;
        wdCntNxt       = wdCnt;
        lpStartNxt     = 1'b0;
        lpStatusPtrNxt = lpStatusPtr;
        lpChanIdNxt    = lpChanId;
        lpAbortNxt     = lpAbort_p;
        chanGrantNxt   = chanGrant;
        chanHaltNxt    = '0;
        chanDeadNxt    = '0;
        timeoutErrNxt  = timeoutErr;

        case (state)
            IDLE: begin
                if (|chanReq) stateNxt = ARB;
            end
            ARB: begin
                if (winFound) begin
                    lpChanIdNxt    = winIdx;
                    chanGrantNxt   = NCHAN'(1) << winIdx;
                    lpStatusPtrNxt = chanStatusPtr[32*winIdx +: 32];
                    stateNxt       = START;
                end else begin
                    stateNxt = IDLE;
                end
            end
            START: begin
                lpStartNxt = 1'b1;
                wdCntNxt   = '0;
                outcomeNxt = OC_NONE;
                stateNxt   = BUSY;
            end
            BUSY: begin
                wdCntNxt = lpProgress_p ? '0 : wdCnt + WDW'(1);
                if (lpDead_p) begin
                    outcomeNxt = OC_DEAD;
                    stateNxt   = RELEASE;
                end else if (lpHalt_p) begin
                    outcomeNxt = OC_HALT;
                    stateNxt   = RELEASE;
                end else if (lpDone_p) begin
                    outcomeNxt = OC_NONE;
                    stateNxt   = RELEASE;
                end else if (!chanReq[lpChanId]) begin
                    lpAbortNxt = 1'b1;
                    stateNxt   = ABORT;
                end else if (wdExpire) begin
                    lpAbortNxt    = 1'b1;
                    timeoutErrNxt = 1'b1;
                    outcomeNxt    = OC_DEAD;
                    stateNxt      = ABORT;
                end
            end
            ABORT: begin
                // Dead reported while stopping outranks halt.
                if (lpDead_p) begin
                    outcomeNxt = OC_DEAD;
                end else if (lpHalt_p && (outcome != OC_DEAD)) begin
                    outcomeNxt = OC_HALT;
                end
                if (lpAbortAck_p) stateNxt = RELEASE;
            end
            RELEASE: begin
                if (outcome == OC_HALT) chanHaltNxt = chanGrant;
                if (outcome == OC_DEAD) chanDeadNxt = chanGrant;
                chanGrantNxt = '0;
                lpAbortNxt   = 1'b0;
                rrPtrNxt     = (lpChanId == CHW'(NCHAN - 1)) ? '0 : lpChanId + CHW'(1);
                stateNxt     = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        // Soft reset returns everything to its power-on values on this edge.
        if (!macPITxClkSoftRst_n) begin
            stateNxt       = IDLE;
            outcomeNxt     = OC_NONE;
            rrPtrNxt       = '0;
            wdCntNxt       = '0;
            lpStartNxt     = 1'b0;
            lpStatusPtrNxt = '0;
            lpChanIdNxt    = '0;
            lpAbortNxt     = 1'b0;
            chanGrantNxt   = '0;
            chanHaltNxt    = '0;
            chanDeadNxt    = '0;
            timeoutErrNxt  = 1'b0;
        end
    end

    always_ff @(posedge macPITxClk or negedge macPITxClkHardRst_n) begin
        if (!macPITxClkHardRst_n) begin
            state       <= IDLE;
            outcome     <= OC_NONE;
            rrPtr       <= '0;
            wdCnt       <= '0;
            lpStart_p   <= 1'b0;
            lpStatusPtr <= '0;
            lpChanId    <= '0;
            lpAbort_p   <= 1'b0;
            chanGrant   <= '0;
            chanHalt_p  <= '0;
            chanDead_p  <= '0;
            timeoutErr  <= 1'b0;
        end else begin
            state       <= stateNxt;
            outcome     <= outcomeNxt;
            rrPtr       <= rrPtrNxt;
            wdCnt       <= wdCntNxt;
            lpStart_p   <= lpStartNxt;
            lpStatusPtr <= lpStatusPtrNxt;
            lpChanId    <= lpChanIdNxt;
            lpAbort_p   <= lpAbortNxt;
            chanGrant   <= chanGrantNxt;
            chanHalt_p  <= chanHaltNxt;
            chanDead_p  <= chanDeadNxt;
            timeoutErr  <= timeoutErrNxt;
        end
    end

    assign schedState = state;

endmodule
